// File: rtl/exc_pkg.sv
// Shared definitions for the exception/interrupt sequencer.
//   - ExcCode constants written into Cause.ExcCode
//   - default exception entry address
//   - sequencer state encoding
//   - helper: which codes also update BadVAddr
package exc_pkg;

  localparam logic [4:0] EXC_INT  = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  localparam logic [4:0] EXC_RI   = 5'd10;
  localparam logic [4:0] EXC_OV   = 5'd12;

  localparam logic [31:0] VECTOR_DEFAULT = 32'h0000_4180;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StTrap   = 2'd1,
    StSettle = 2'd2
  } exc_state_e;

  // Address-error traps are the only ones that record the faulting address.
  function automatic logic is_addr_err(input logic [4:0] code);
    return (code == EXC_ADEL) || (code == EXC_ADES);
  endfunction

endpackage

// File: rtl/exc_prio.sv
// Trigger priority encoder for the exception sequencer (purely combinational).
// Ports:
//   i_valid     M stage holds a real instruction
//   i_int_p     qualified interrupt pending
//   i_exception exception flag carried to M
//   i_exc_code  ExcCode carried to M
//   i_eret      eret in M
//   o_trig      some event is taken this cycle
//   o_is_eret   the taken event is an eret
//   o_code      ExcCode of the taken event (EXC_INT for eret, unused there)
module exc_prio
  import exc_pkg::*;
(
  input  logic       i_valid,
  input  logic       i_int_p,
  input  logic       i_exception,
  input  logic [4:0] i_exc_code,
  input  logic       i_eret,
  output logic       o_trig,
  output logic       o_is_eret,
  output logic [4:0] o_code
);

  always_comb begin
    o_trig    = 1'b0;
    o_is_eret = 1'b0;
    o_code    = EXC_INT;
    // Bubbles never trap; a pending interrupt waits for a real instruction.
    if (i_valid) begin
      if (i_int_p) begin
        o_trig = 1'b1;
        o_code = EXC_INT;
      end else if (i_exception) begin
        o_trig = 1'b1;
        o_code = i_exc_code;
      end else if (i_eret) begin
        o_trig    = 1'b1;
        o_is_eret = 1'b1;
      end
    end
  end

endmodule

// File: rtl/exc_ctrl.sv
// Exception/interrupt sequencer for the 5-stage pipeline.
// Picks one event per trap (interrupt > exception > eret) from the M stage,
// kills the M instruction, then runs TRAP (commit + flush + redirect) and
// SETTLE (flush only) before looking at triggers again.
// Ports:
//   clk, reset                    clock, synchronous active-high reset
//   ValidM, ExceptionM, ExcM      M-stage validity, exception flag and code
//   PCM, BDM, BadVAddrM           M-stage PC, delay-slot flag, faulting address
//   EretM                         eret in M
//   HWInt, IM, IE, EXL            interrupt lines and CP0 status bits
//   EPCIn                         current CP0 EPC (eret target)
//   KillM                         suppress M write / W writeback (combinational)
//   ExcCommit, EretCommit         one-cycle CP0 strobes
//   EPCOut, ExcCodeOut, BDOut     registered values for EPC / Cause
//   BadVAddrOut, BadVAddrWe       registered BadVAddr value and its enable
//   Flush, Redirect, RedirectPC   pipeline flush and PC override
//   Busy                          sequencer not idle
module exc_ctrl
  import exc_pkg::*;
#(
  parameter logic [31:0] VECTOR = VECTOR_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ValidM,
  input  logic        ExceptionM,
  input  logic [4:0]  ExcM,
  input  logic [31:0] PCM,
  input  logic        BDM,
  input  logic [31:0] BadVAddrM,
  input  logic        EretM,
  input  logic [5:0]  HWInt,
  input  logic [5:0]  IM,
  input  logic        IE,
  input  logic        EXL,
  input  logic [31:0] EPCIn,
  output logic        KillM,
  output logic        ExcCommit,
  output logic        EretCommit,
  output logic [31:0] EPCOut,
  output logic [4:0]  ExcCodeOut,
  output logic        BDOut,
  output logic [31:0] BadVAddrOut,
  output logic        BadVAddrWe,
  output logic        Flush,
  output logic        Redirect,
  output logic [31:0] RedirectPC,
  output logic        Busy
);

  exc_state_e  r_state;
  exc_state_e  w_state_nxt;
  logic [31:0] r_epc;
  logic [4:0]  r_code;
  logic        r_bd;
  logic [31:0] r_badvaddr;
  logic        r_eret;

  logic        w_int_p;
  logic        w_trig;
  logic        w_is_eret;
  logic [4:0]  w_code;
  logic        w_take;
  logic [31:0] w_epc;

  // EXL masks interrupts only; exceptions are still taken under EXL.
  assign w_int_p = (|(HWInt & IM)) & IE & ~EXL;

  exc_prio u_prio (
    .i_valid     (ValidM),
    .i_int_p     (w_int_p),
    .i_exception (ExceptionM),
    .i_exc_code  (ExcM),
    .i_eret      (EretM),
    .o_trig      (w_trig),
    .o_is_eret   (w_is_eret),
    .o_code      (w_code)
  );

  assign w_take = (r_state == StIdle) && w_trig && !reset;

  // A delay-slot instruction restarts at its branch.
  assign w_epc = BDM ? (PCM - 32'd4) : PCM;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= StIdle;
      r_epc      <= '0;
      r_code     <= '0;
      r_bd       <= 1'b0;
      r_badvaddr <= '0;
      r_eret     <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_take) begin
        r_epc      <= w_epc;
        r_code     <= w_code;
        r_bd       <= BDM;
        r_badvaddr <= BadVAddrM;
        r_eret     <= w_is_eret;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    KillM       = 1'b0;
    ExcCommit   = 1'b0;
    EretCommit  = 1'b0;
    BadVAddrWe  = 1'b0;
    Flush       = 1'b0;
    Redirect    = 1'b0;
    RedirectPC  = '0;
    unique case (r_state)
      StIdle: begin
        if (w_take) begin
          KillM       = 1'b1;
          w_state_nxt = StTrap;
        end
      end
      StTrap: begin
        Flush    = 1'b1;
        Redirect = 1'b1;
        if (r_eret) begin
          EretCommit = 1'b1;
          RedirectPC = EPCIn;
        end else begin
          ExcCommit  = 1'b1;
          RedirectPC = VECTOR;
          BadVAddrWe = is_addr_err(r_code);
        end
        w_state_nxt = StSettle;
      end
      StSettle: begin
        // Squash the wrong-path fetch issued while redirecting.
        Flush       = 1'b1;
        w_state_nxt = StIdle;
      end
      default: w_state_nxt = StIdle;
    endcase
    // Outputs read as idle while reset is held, even mid-sequence.
    if (reset) begin
      ExcCommit  = 1'b0;
      EretCommit = 1'b0;
      BadVAddrWe = 1'b0;
      Flush      = 1'b0;
      Redirect   = 1'b0;
      RedirectPC = '0;
    end
  end

  assign Busy        = (r_state != StIdle) && !reset;
  assign EPCOut      = r_epc;
  assign ExcCodeOut  = r_code;
  assign BDOut       = r_bd;
  assign BadVAddrOut = r_badvaddr;

endmodule

// File: tb/tb_exc_ctrl.sv
// Directed self-checking bench for exc_ctrl.
module tb_exc_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        ValidM, ExceptionM, BDM, EretM, IE, EXL;
  logic [4:0]  ExcM;
  logic [31:0] PCM, BadVAddrM, EPCIn;
  logic [5:0]  HWInt, IM;
  logic        KillM, ExcCommit, EretCommit, BDOut, BadVAddrWe, Flush, Redirect, Busy;
  logic [31:0] EPCOut, BadVAddrOut, RedirectPC;
  logic [4:0]  ExcCodeOut;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  exc_ctrl #(.VECTOR(32'h0000_4180)) dut (
    .clk         (clk),
    .reset       (reset),
    .ValidM      (ValidM),
    .ExceptionM  (ExceptionM),
    .ExcM        (ExcM),
    .PCM         (PCM),
    .BDM         (BDM),
    .BadVAddrM   (BadVAddrM),
    .EretM       (EretM),
    .HWInt       (HWInt),
    .IM          (IM),
    .IE          (IE),
    .EXL         (EXL),
    .EPCIn       (EPCIn),
    .KillM       (KillM),
    .ExcCommit   (ExcCommit),
    .EretCommit  (EretCommit),
    .EPCOut      (EPCOut),
    .ExcCodeOut  (ExcCodeOut),
    .BDOut       (BDOut),
    .BadVAddrOut (BadVAddrOut),
    .BadVAddrWe  (BadVAddrWe),
    .Flush       (Flush),
    .Redirect    (Redirect),
    .RedirectPC  (RedirectPC),
    .Busy        (Busy)
  );

  // Inputs change just after a rising edge; outputs are sampled at the falling edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    ValidM = 0; ExceptionM = 0; ExcM = 0; PCM = 0; BDM = 0; BadVAddrM = 0;
    EretM = 0; HWInt = 0; IM = 0; IE = 0; EXL = 0; EPCIn = 0;
  endtask

  task automatic settle_idle();
    clear_inputs();
    repeat (3) tick();
  endtask

  task automatic test_reset();
    clear_inputs();
    reset = 1;
    ValidM = 1; ExceptionM = 1; ExcM = 10;
    repeat (2) tick();
    @(negedge clk);
    checks++; if (KillM !== 1'b0) begin errors++; $display("FAIL reset_killm got %b want 0", KillM); end
    checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", Busy); end
    checks++; if (Flush !== 1'b0) begin errors++; $display("FAIL reset_flush got %b want 0", Flush); end
    checks++; if (ExcCommit !== 1'b0) begin errors++; $display("FAIL reset_exccommit got %b want 0", ExcCommit); end
    checks++; if (EPCOut !== 32'h0) begin errors++; $display("FAIL reset_epc got %h want 0", EPCOut); end
    tick();
    reset = 0;
    clear_inputs();
    tick();
  endtask

  task automatic test_ri();
    ValidM = 1; ExceptionM = 1; ExcM = 10; PCM = 32'h3010; BDM = 0; BadVAddrM = 32'h55;
    @(negedge clk);
    checks++; if (KillM !== 1'b1) begin errors++; $display("FAIL ri_killm_t got %b want 1", KillM); end
    checks++; if (ExcCommit !== 1'b0) begin errors++; $display("FAIL ri_commit_t got %b want 0", ExcCommit); end
    tick();
    clear_inputs();
    @(negedge clk);
    checks++; if (ExcCommit !== 1'b1) begin errors++; $display("FAIL ri_exccommit got %b want 1", ExcCommit); end
    checks++; if (EPCOut !== 32'h3010) begin errors++; $display("FAIL ri_epc got %h want 3010", EPCOut); end
    checks++; if (ExcCodeOut !== 5'd10) begin errors++; $display("FAIL ri_code got %0d want 10", ExcCodeOut); end
    checks++; if (RedirectPC !== 32'h4180) begin errors++; $display("FAIL ri_redirpc got %h want 4180", RedirectPC); end
    checks++; if (Redirect !== 1'b1) begin errors++; $display("FAIL ri_redirect got %b want 1", Redirect); end
    checks++; if (BadVAddrWe !== 1'b0) begin errors++; $display("FAIL ri_bvawe got %b want 0", BadVAddrWe); end
    checks++; if (Flush !== 1'b1) begin errors++; $display("FAIL ri_flush_t1 got %b want 1", Flush); end
    checks++; if (KillM !== 1'b0) begin errors++; $display("FAIL ri_killm_trap got %b want 0", KillM); end
    checks++; if (EretCommit !== 1'b0) begin errors++; $display("FAIL ri_eretcommit got %b want 0", EretCommit); end
    tick();
    @(negedge clk);
    checks++; if (Flush !== 1'b1) begin errors++; $display("FAIL ri_flush_t2 got %b want 1", Flush); end
    checks++; if (Redirect !== 1'b0) begin errors++; $display("FAIL ri_redirect_t2 got %b want 0", Redirect); end
    checks++; if (ExcCommit !== 1'b0) begin errors++; $display("FAIL ri_commit_t2 got %b want 0", ExcCommit); end
    checks++; if (Busy !== 1'b1) begin errors++; $display("FAIL ri_busy_t2 got %b want 1", Busy); end
    tick();
    @(negedge clk);
    checks++; if (Flush !== 1'b0) begin errors++; $display("FAIL ri_flush_t3 got %b want 0", Flush); end
    checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL ri_busy_t3 got %b want 0", Busy); end
    checks++; if (EPCOut !== 32'h3010) begin errors++; $display("FAIL ri_epc_hold got %h want 3010", EPCOut); end
    settle_idle();
  endtask

  task automatic test_adel();
    ValidM = 1; ExceptionM = 1; ExcM = 4; PCM = 32'h3024; BDM = 1; BadVAddrM = 32'h7f01;
    tick();
    clear_inputs();
    @(negedge clk);
    checks++; if (EPCOut !== 32'h3020) begin errors++; $display("FAIL adel_epc got %h want 3020", EPCOut); end
    checks++; if (BDOut !== 1'b1) begin errors++; $display("FAIL adel_bd got %b want 1", BDOut); end
    checks++; if (BadVAddrWe !== 1'b1) begin errors++; $display("FAIL adel_bvawe got %b want 1", BadVAddrWe); end
    checks++; if (BadVAddrOut !== 32'h7f01) begin errors++; $display("FAIL adel_bva got %h want 7f01", BadVAddrOut); end
    settle_idle();
    // AdES in a delay slot at PC 0: EPC wraps modulo 2^32.
    ValidM = 1; ExceptionM = 1; ExcM = 5; PCM = 32'h0; BDM = 1; BadVAddrM = 32'h8001;
    tick();
    clear_inputs();
    @(negedge clk);
    checks++; if (EPCOut !== 32'hffff_fffc) begin errors++; $display("FAIL ades_epc_wrap got %h want fffffffc", EPCOut); end
    checks++; if (BadVAddrWe !== 1'b1) begin errors++; $display("FAIL ades_bvawe got %b want 1", BadVAddrWe); end
    checks++; if (ExcCodeOut !== 5'd5) begin errors++; $display("FAIL ades_code got %0d want 5", ExcCodeOut); end
    settle_idle();
  endtask

  task automatic test_int_prio();
    ValidM = 1; ExceptionM = 1; ExcM = 12; PCM = 32'h3030;
    HWInt = 6'b000100; IM = 6'b000100; IE = 1; EXL = 0;
    tick();
    clear_inputs();
    @(negedge clk);
    checks++; if (ExcCodeOut !== 5'd0) begin errors++; $display("FAIL int_code got %0d want 0", ExcCodeOut); end
    checks++; if (ExcCommit !== 1'b1) begin errors++; $display("FAIL int_commit got %b want 1", ExcCommit); end
    settle_idle();
    ValidM = 1; ExceptionM = 1; ExcM = 12; PCM = 32'h3030;
    HWInt = 6'b000100; IM = 6'b000100; IE = 1; EXL = 1;
    tick();
    clear_inputs();
    @(negedge clk);
    checks++; if (ExcCodeOut !== 5'd12) begin errors++; $display("FAIL int_exl_code got %0d want 12", ExcCodeOut); end
    checks++; if (ExcCommit !== 1'b1) begin errors++; $display("FAIL int_exl_commit got %b want 1", ExcCommit); end
    settle_idle();
    ValidM = 0; ExceptionM = 1; ExcM = 12;
    HWInt = 6'b000100; IM = 6'b000100; IE = 1; EXL = 0;
    @(negedge clk);
    checks++; if (KillM !== 1'b0) begin errors++; $display("FAIL novalid_killm got %b want 0", KillM); end
    tick();
    @(negedge clk);
    checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL novalid_busy got %b want 0", Busy); end
    checks++; if (ExcCommit !== 1'b0) begin errors++; $display("FAIL novalid_commit got %b want 0", ExcCommit); end
    settle_idle();
  endtask

  task automatic test_eret();
    ValidM = 1; EretM = 1; EPCIn = 32'h3044;
    @(negedge clk);
    checks++; if (KillM !== 1'b1) begin errors++; $display("FAIL eret_killm got %b want 1", KillM); end
    tick();
    ValidM = 0; EretM = 0;
    @(negedge clk);
    checks++; if (EretCommit !== 1'b1) begin errors++; $display("FAIL eret_commit got %b want 1", EretCommit); end
    checks++; if (ExcCommit !== 1'b0) begin errors++; $display("FAIL eret_exccommit got %b want 0", ExcCommit); end
    checks++; if (RedirectPC !== 32'h3044) begin errors++; $display("FAIL eret_redirpc got %h want 3044", RedirectPC); end
    checks++; if (BadVAddrWe !== 1'b0) begin errors++; $display("FAIL eret_bvawe got %b want 0", BadVAddrWe); end
    settle_idle();
    // Exception and eret in the same instruction: the exception wins.
    ValidM = 1; EretM = 1; ExceptionM = 1; ExcM = 10; EPCIn = 32'h3044; PCM = 32'h3050;
    tick();
    clear_inputs();
    @(negedge clk);
    checks++; if (ExcCommit !== 1'b1) begin errors++; $display("FAIL exc_eret_commit got %b want 1", ExcCommit); end
    checks++; if (EretCommit !== 1'b0) begin errors++; $display("FAIL exc_eret_eretcommit got %b want 0", EretCommit); end
    checks++; if (RedirectPC !== 32'h4180) begin errors++; $display("FAIL exc_eret_redirpc got %h want 4180", RedirectPC); end
    settle_idle();
  endtask

  task automatic test_back_to_back();
    ValidM = 1; ExceptionM = 1; ExcM = 12; PCM = 32'h3100;
    for (int c = 0; c < 9; c++) begin
      @(negedge clk);
      checks++;
      if (KillM !== (c % 3 == 0)) begin
        errors++; $display("FAIL b2b_killm cycle %0d got %b want %b", c, KillM, (c % 3 == 0));
      end
      checks++;
      if (ExcCommit !== (c % 3 == 1)) begin
        errors++; $display("FAIL b2b_commit cycle %0d got %b want %b", c, ExcCommit, (c % 3 == 1));
      end
      tick();
    end
    settle_idle();
  endtask

  task automatic test_reset_mid();
    ValidM = 1; ExceptionM = 1; ExcM = 4; PCM = 32'h3200; BadVAddrM = 32'h99;
    tick();
    clear_inputs();
    reset = 1;
    tick();
    reset = 0;
    @(negedge clk);
    checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL rmid_busy got %b want 0", Busy); end
    checks++; if (Flush !== 1'b0) begin errors++; $display("FAIL rmid_flush got %b want 0", Flush); end
    checks++; if (ExcCommit !== 1'b0) begin errors++; $display("FAIL rmid_commit got %b want 0", ExcCommit); end
    checks++; if (Redirect !== 1'b0) begin errors++; $display("FAIL rmid_redirect got %b want 0", Redirect); end
    checks++; if (EPCOut !== 32'h0) begin errors++; $display("FAIL rmid_epc got %h want 0", EPCOut); end
    checks++; if (ExcCodeOut !== 5'd0) begin errors++; $display("FAIL rmid_code got %0d want 0", ExcCodeOut); end
    checks++; if (BadVAddrOut !== 32'h0) begin errors++; $display("FAIL rmid_bva got %h want 0", BadVAddrOut); end
    tick();
    @(negedge clk);
    checks++; if (Flush !== 1'b0) begin errors++; $display("FAIL rmid_noresume got %b want 0", Flush); end
    checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL rmid_busy2 got %b want 0", Busy); end
    settle_idle();
  endtask

  initial begin
    clear_inputs();
    reset = 1;
    test_reset();
    test_ri();
    test_adel();
    test_int_prio();
    test_eret();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
